shift_exec_16: RTL and testbench

//  Two-stage pipelined shift execute unit for the 16-bit datapath.
//  - Accepts {data, binary shift amount, op} over a valid/ready handshake.
//  - Decodes the amount to a one-hot select and drives the one-hot left-shift core.
//  - Right shifts are built by bit-reversal around that core.
//  - Registers the result toward the writeback stage with backpressure.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_onehot_16.sv | 23 ++
 rtl/shift_exec_16.sv | 130 +++++++++++++
 tb/tb_shift_exec_16.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the 16-bit shift execute unit.
//   WIDTH / SHW : datapath width and shift-amount width
//   op_e        : operation encodings carried on in_op
//   bitrev16    : bit reversal used to build right shifts from a left-shift core
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11   // rotate-left, or pass-through when rotate is not built
    } op_e;

    function automatic logic [15:0] bitrev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = x[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_onehot_16.sv
// Combinational left shift driven by a one-hot amount select.
//   data : operand
//   sel  : one-hot shift amount (bit i set -> shift by i); all-zero -> result 0
//   res  : data << index(sel), bits shifted past the MSB are dropped
module shift_onehot_16
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] sel,
    output logic [WIDTH-1:0] res
);

    // OR of gated shifted copies; with a one-hot select exactly one term survives.
    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i]) begin
                res = res | (data << i);
            end
        end
    end

endmodule

// File: rtl/shift_exec_16.sv
// Two-stage pipelined shift execute unit (16-bit).
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : request handshake; in_data, in_shamt (0..15), in_op
//   out_valid/out_ready : result handshake toward writeback
//   out_data, out_zero  : registered result and its zero flag
// Stage 1 registers the operand, op and the decoded one-hot amount.
// Stage 2 computes the shift with two one-hot left-shift cores (data path
// and fill mask) and registers the result.
// Build option: define SHIFT_EXEC_ROTATE_EN to make op 11 a rotate-left;
// without it op 11 passes the operand through unchanged.
module shift_exec_16 #(
    parameter int               WIDTH   = 16,
    parameter int               SHW     = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] RST_RES = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    import shift_pkg::*;

    if (WIDTH != 16) begin : g_width_check
        $error("shift_exec_16: only WIDTH=16 is supported");
    end

    // Stage 1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s1_onehot;
    op_e              s1_op;

    logic s2_adv, s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;

    // Stage 2 datapath
    logic [WIDTH-1:0] dat_in, dat_out;
    logic [WIDTH-1:0] mask_in, mask_sel, mask_out;
    logic [WIDTH-1:0] res;
    logic             is_right;

    assign is_right = (s1_op == OP_SRL) || (s1_op == OP_SRA);
    // Right shifts run through the left-shift core on the reversed operand.
    assign dat_in   = is_right ? bitrev16(s1_data) : s1_data;

`ifdef SHIFT_EXEC_ROTATE_EN
    // For rotate, the mask core is reused to compute SRL(d, (16-n) mod 16).
    // That amount's one-hot is the reversed select rotated left by one
    // (bit n -> bit 15-n -> bit (16-n) mod 16).
    logic [WIDTH-1:0] rev_oh, rot_sel;
    assign rev_oh   = bitrev16(s1_onehot);
    assign rot_sel  = {rev_oh[WIDTH-2:0], rev_oh[WIDTH-1]};
    assign mask_in  = (s1_op == OP_ROL) ? bitrev16(s1_data) : '1;
    assign mask_sel = (s1_op == OP_ROL) ? rot_sel : s1_onehot;
`else
    assign mask_in  = '1;
    assign mask_sel = s1_onehot;
`endif

    shift_onehot_16 u_dat (
        .data (dat_in),
        .sel  (s1_onehot),
        .res  (dat_out)
    );

    shift_onehot_16 u_mask (
        .data (mask_in),
        .sel  (mask_sel),
        .res  (mask_out)
    );

    always_comb begin
        res = s1_data;
        case (s1_op)
            OP_SLL: res = dat_out;
            OP_SRL: res = bitrev16(dat_out);
            // Sign fill: ~R(L(FFFF)) has exactly the top n bits set.
            OP_SRA: res = bitrev16(dat_out) |
                          (s1_data[WIDTH-1] ? ~bitrev16(mask_out) : '0);
`ifdef SHIFT_EXEC_ROTATE_EN
            OP_ROL: res = dat_out | bitrev16(mask_out);
`else
            OP_ROL: res = s1_data;
`endif
            default: res = s1_data;
        endcase
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= RST_RES;
            out_zero  <= (RST_RES == '0);
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_data <= res;
                out_zero <= (res == '0);
            end
            if (in_ready) begin
                s1_valid <= in_valid;
            end
        end
    end

    // Stage 1 payload is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_data   <= in_data;
            s1_op     <= op_e'(in_op);
            s1_onehot <= {{(WIDTH-1){1'b0}}, 1'b1} << in_shamt;
        end
    end

endmodule

// File: tb/tb_shift_exec_16.sv
// Self-checking bench for shift_exec_16: directed cases plus a randomized run
// against an arithmetic reference model with an in-order scoreboard.
module tb_shift_exec_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_zero;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] seen_q[$];
    bit          acc, drn;

    always #5 clk = ~clk;

    shift_exec_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    function automatic logic [15:0] ref_model(input logic [15:0] d, input int n, input logic [1:0] op);
        logic [15:0] r;
        case (op)
            2'b00: r = d << n;
            2'b01: r = d >> n;
            2'b10: r = 16'($signed(d) >>> n);
`ifdef SHIFT_EXEC_ROTATE_EN
            default: r = (n == 0) ? d : 16'((d << n) | (d >> (16 - n)));
`else
            default: r = d;
`endif
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called in the low clock phase: evaluates handshakes, updates the
    // scoreboard, then advances through one rising edge.
    task automatic cyc();
        logic [15:0] e;
        #1;
        acc = in_valid && in_ready && !rst;
        drn = out_valid && out_ready && !rst;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (drn) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e));
                    chk("sb_zero", 32'(out_zero), 32'(e == 16'h0));
                    seen_q.push_back(out_data);
                end
            end
            if (acc) exp_q.push_back(ref_model(in_data, int'(in_shamt), in_op));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single request into an empty pipe with out_ready=1; checks 2-cycle latency.
    task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] n,
                            input logic [1:0] op, input logic [15:0] expv);
        in_valid = 1'b1; in_data = d; in_shamt = n; in_op = op;
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        cyc();
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(expv));
        chk({tag, "_zero"}, 32'(out_zero), 32'(expv == 16'h0));
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, cycles;
        logic [15:0] exp_rot;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_zero",  32'(out_zero),  32'd1);
        rst = 1'b0;

        // SLL sweep
        for (int n = 0; n < 16; n++) begin
            send_one("sll", 16'h000F, 4'(n), 2'b00, 16'(16'h000F << n));
        end

        send_one("srl_8000_15", 16'h8000, 4'd15, 2'b01, 16'h0001);
        send_one("sra_8000_15", 16'h8000, 4'd15, 2'b10, 16'hFFFF);
        send_one("sra_7ff0_4",  16'h7FF0, 4'd4,  2'b10, 16'h07FF);
        send_one("sra_n0",      16'h9234, 4'd0,  2'b10, 16'h9234);
        send_one("srl_zero",    16'h0001, 4'd1,  2'b01, 16'h0000);
`ifdef SHIFT_EXEC_ROTATE_EN
        exp_rot = 16'h0003;
`else
        exp_rot = 16'h8001;
`endif
        send_one("op11", 16'h8001, 4'd1, 2'b11, exp_rot);

        // Stall: A, B accepted, C blocked; then all emerge in order.
        seen_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0A0A; in_shamt = 4'd0; in_op = 2'b00;
        cyc();
        chk("stall_acc_a", 32'(acc), 32'd1);
        in_data = 16'h0B0B;
        cyc();
        chk("stall_acc_b", 32'(acc), 32'd1);
        in_data = 16'h0C0C;
        cyc();
        chk("stall_block_c", 32'(acc), 32'd0);
        cyc();
        chk("stall_ready_low", 32'(in_ready), 32'd0);
        chk("stall_hold_a", 32'(out_data), 32'h0A0A);
        out_ready = 1'b1;
        cycles = 0;
        while (!acc && cycles < 10) begin cyc(); cycles++; end
        chk("stall_c_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 10) begin cyc(); cycles++; end
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        chk("stall_count", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            chk("stall_order_a", 32'(seen_q[0]), 32'h0A0A);
            chk("stall_order_b", 32'(seen_q[1]), 32'h0B0B);
            chk("stall_order_c", 32'(seen_q[2]), 32'h0C0C);
        end
        cyc();
        chk("stall_no_dup", 32'(out_valid), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; in_shamt = 4'd3; in_op = 2'b00;
        cyc();
        in_data = 16'h5678;
        cyc();
        chk("full_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("rstfull_out_valid", 32'(out_valid), 32'd0);
        chk("rstfull_in_ready",  32'(in_ready),  32'd1);
        chk("rstfull_out_data",  32'(out_data),  32'h0);
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rstfull_discarded", 32'(out_valid), 32'd0);

        // Randomized run with random backpressure.
        sent = 0; cycles = 0;
        while ((sent < 400 || in_valid || exp_q.size() > 0) && cycles < 5000) begin
            if (!in_valid && sent < 400 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                in_shamt = 4'($urandom_range(0, 15));
                in_op    = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cycles++;
        end
        chk("rand_all_sent", 32'(sent), 32'd400);
        chk("rand_all_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
